aes_key_expand: RTL
===================

Name: aes_key_expand

Overview:
Iterative AES-128 key-schedule generator that sits directly upstream of the round datapath and owns the SubWord stage. It captures a 128-bit cipher key on a start pulse, then emits round keys 0..10 one per accepted transfer over a valid/ready stream. Each next round key is derived from the current one with a single shared instance of the team's Sub_byte word-substitution module.

Parameters:
NUM_ROUNDS, 10, index of the last round key emitted; AES-128 only, other values unsupported.

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; honoured only in IDLE
key_in  input  128  cipher key, sampled when start is honoured; w0 = key_in[127:96]
busy  output  1  high from the cycle after start is honoured until done
rk_valid  output  1  rk_data/rk_idx hold a valid round key
rk_ready  input  1  downstream accepts the key when rk_valid && rk_ready
rk_data  output  128  current round key, same word order as key_in
rk_idx  output  4  round index of rk_data, 0..NUM_ROUNDS
done  output  1  one-cycle pulse after key NUM_ROUNDS is accepted

Behaviour:
- Reset, asynchronous while rst=1: state=IDLE, busy=0, rk_valid=0, rk_data=0, rk_idx=0, done=0, rcon=8'h01.
- State IDLE: if start=1 at edge T, then rk_data<=key_in, rk_idx<=0, rcon<=8'h01, state<=OUT. At T+1 rk_valid=1 and busy=1. Latency from start to key 0 is one cycle.
- State OUT: rk_valid=1. rk_data and rk_idx are stable while rk_ready=0, with no limit on stall length.
  - On an accept with rk_idx<NUM_ROUNDS: rk_data<=next_key, rk_idx<=rk_idx+1, rcon<=xtime(rcon). rk_valid stays high, so throughput is one key per cycle.
  - On an accept with rk_idx==NUM_ROUNDS: rk_valid<=0, state<=DONE.
- State DONE: done=1 and busy=0 for exactly one cycle, then state<=IDLE. start is ignored in DONE.
- start in OUT or DONE is ignored. key_in is not resampled and has no effect.
- next_key is combinational from the registered rk_data (words w0..w3):
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord(x) = {x[23:0], x[31:24]}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- SubWord is a single Sub_byte instance with its start input tied to 1'b1 and W=RotWord(w3). The lookup is purely combinational.
- rcon update: xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00). The sequence used for rounds 1..10 is 01,02,04,08,10,20,40,80,1B,36.
- All arithmetic is bitwise XOR with no carries. rk_idx never exceeds NUM_ROUNDS and never wraps.
- A reset asserted mid-sequence aborts immediately and returns to the reset values. No partial key is presented afterwards.
- Outputs are registered. rk_valid does not depend combinationally on rk_ready.

Decomposition:
- Shared package aes_pkg holds: AES_NK=4, AES_NR=10, the word/key typedefs (32-bit word, 128-bit block), and the rot_word and xtime functions.
- Natural sub-module: Sub_byte, instantiated once for SubWord.
- The FSM, rcon register and next_key XOR chain stay inline.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1:
  - key 0 appears one cycle after start.
  - key 1 = a0fafe1788542cb123a339392a6c7605.
  - key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Eleven consecutive valid cycles, then a done pulse.
- All-zero key:
  - key 1 = 62636363626363636263636362636363.
  - key 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: same FIPS key with rk_ready toggled randomly, including a 20-cycle stall at idx 8.
  - rk_data and rk_idx stay stable while stalled.
  - The accepted sequence matches the no-stall run exactly.
- start pulsed with a different key_in during OUT and during DONE:
  - It is ignored and the sequence is unchanged.
  - A new start in IDLE afterwards captures the new key.
- rst asserted at idx 5 for one cycle, asynchronously mid-cycle:
  - rk_valid, busy, rk_idx and rk_data drop to 0 immediately.
  - done is never pulsed.
  - A following start restarts from idx 0.
- Ready tied low after key 0: rk_valid stays high indefinitely with idx 0 and done stays 0. Releasing rk_ready completes the normal sequence.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, word/block types and byte/word helpers used by the key schedule.
package aes_pkg;

    localparam int unsigned AES_NK = 4;
    localparam int unsigned AES_NR = 10;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        StIdle,
        StOut,
        StDone
    } kx_state_e;

    function automatic aes_word_t rot_word(input aes_word_t x);
        return {x[23:0], x[31:24]};
    endfunction

    // GF(2^8) multiply-by-x with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Control and round-key stream bundle between the key schedule and its consumer.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic       start;
    aes_block_t key_in;
    logic       busy;
    logic       rk_valid;
    logic       rk_ready;
    aes_block_t rk_data;
    logic [3:0] rk_idx;
    logic       done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_data, rk_idx, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_data, rk_idx, done
    );

endinterface

// File: rtl/Sub_byte.sv
// Combinational SubWord: AES S-box applied to each byte of a 32-bit word.
module Sub_byte
    import aes_pkg::*;
(
    input  logic      i_start,
    input  aes_word_t i_w,
    output aes_word_t o_w
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    always_comb begin
        o_w = '0;
        if (i_start) begin
            for (int j = 0; j < 4; j++) begin
                o_w[8*j +: 8] = sbox(i_w[8*j +: 8]);
            end
        end
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: captures a key on start and streams round keys 0..NUM_ROUNDS.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NR
) (
    input logic             clk,
    input logic             rst,
    aes_key_expand_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    kx_state_e  r_state;
    kx_state_e  w_state_next;
    aes_block_t r_rk_data;
    logic [3:0] r_rk_idx;
    logic [7:0] r_rcon;

    logic       w_accept;
    logic       w_last;
    aes_word_t  w_sub_out;
    aes_word_t  w_t;
    aes_word_t  w_chain;
    aes_block_t w_next_key;

    assign w_accept = (r_state == StOut) && bus.rk_ready;
    assign w_last   = (r_rk_idx == LAST_IDX);

    Sub_byte u_sub_byte (
        .i_start (1'b1),
        .i_w     (rot_word(r_rk_data[31:0])),
        .o_w     (w_sub_out)
    );

    assign w_t = w_sub_out ^ {r_rcon, 24'h0};

    // Word i of the next key is word i of the current key XOR word i-1 of the next key.
    always_comb begin
        w_chain    = w_t;
        w_next_key = '0;
        for (int i = 0; i < AES_NK; i++) begin
            w_chain                   = r_rk_data[127-32*i -: 32] ^ w_chain;
            w_next_key[127-32*i -: 32] = w_chain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StOut;
            StOut:   if (w_accept && w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.busy     = (r_state == StOut);
        bus.rk_valid = (r_state == StOut);
        bus.done     = (r_state == StDone);
        bus.rk_data  = r_rk_data;
        bus.rk_idx   = r_rk_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rk_data <= '0;
            r_rk_idx  <= '0;
            r_rcon    <= 8'h01;
        end else if (r_state == StIdle && bus.start) begin
            r_rk_data <= bus.key_in;
            r_rk_idx  <= '0;
            r_rcon    <= 8'h01;
        end else if (w_accept && !w_last) begin
            r_rk_data <= w_next_key;
            r_rk_idx  <= r_rk_idx + 4'd1;
            r_rcon    <= xtime(r_rcon);
        end
    end

endmodule
